bits_literal_decoder: RTL and testbench

Multi-cycle decoder for BITS literal-value payloads, the responder on the `encoded_number`/`decodeNumber` interface driven by `bits_fsm`. It accepts an 80-bit MSB-aligned window of 5-bit literal groups. It walks the groups one per cycle, or two per cycle when configured. It returns the assembled 64-bit value, the number of bits consumed, and a one-cycle completion strobe.

---
 rtl/bits_literal_decoder_pkg.sv | 26 ++
 rtl/bits_literal_decoder_if.sv | 47 ++++
 rtl/bits_literal_decoder_group_step.sv | 34 +++
 rtl/bits_literal_decoder.sv | 158 +++++++++++++++
 tb/tb_bits_literal_decoder.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/bits_literal_decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bits_pkg
//  Purpose  : Shared constants and state encoding for the BITS literal
//             decoder slice (decoder top, group step, handshake interface).
//  Contents : LIT_GROUP_W, LIT_MAX_GROUPS, LIT_WINDOW_W, LIT_VALUE_W,
//             LIT_CNT_W, LIT_BITS_W, lit_state_t
//  Revision : 1.0  initial release
// ============================================================================
package bits_pkg;

    localparam int LIT_GROUP_W    = 5;
    localparam int LIT_MAX_GROUPS = 16;
    localparam int LIT_WINDOW_W   = 80;
    localparam int LIT_VALUE_W    = 64;
    localparam int LIT_CNT_W      = 5;   // holds 0..16
    localparam int LIT_BITS_W     = 7;   // holds 0..80

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_DONE   = 2'd2
    } lit_state_t;

endpackage : bits_pkg
`default_nettype wire

// File: rtl/bits_literal_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module   : bits_literal_decoder_if
//  Purpose  : encoded_number/decodeNumber handshake between bits_fsm
//             (master) and bits_literal_decoder (slave).
//  Signals  : encoded_number [79:0]  literal window, MSB-aligned
//             decodeNumber           start request
//             decodedNumber  [63:0]  assembled value
//             bitsToShift    [6:0]   bits consumed (5 x groups)
//             number_valid           one-cycle completion strobe
//             busy                   decoder walking groups
//             overflow               16th group still had continuation set
//  Revision : 1.0  initial release
// ============================================================================
interface bits_literal_decoder_if;
    import bits_pkg::*;

    logic [LIT_WINDOW_W-1:0] encoded_number;
    logic                    decodeNumber;
    logic [LIT_VALUE_W-1:0]  decodedNumber;
    logic [LIT_BITS_W-1:0]   bitsToShift;
    logic                    number_valid;
    logic                    busy;
    logic                    overflow;

    modport master (
        output encoded_number,
        output decodeNumber,
        input  decodedNumber,
        input  bitsToShift,
        input  number_valid,
        input  busy,
        input  overflow
    );

    modport slave (
        input  encoded_number,
        input  decodeNumber,
        output decodedNumber,
        output bitsToShift,
        output number_valid,
        output busy,
        output overflow
    );

endinterface : bits_literal_decoder_if
`default_nettype wire

// File: rtl/bits_literal_decoder_group_step.sv
`default_nettype none
// ============================================================================
//  Module   : bits_lit_group_step
//  Purpose  : Combinational single-group step: splits a 5-bit literal group
//             into continuation flag and nibble and appends the nibble to
//             the accumulator.
//  Ports    : i_group  [4:0]   literal group (bit 4 = continuation)
//             i_acc    [63:0]  accumulator before this group
//             o_acc    [63:0]  accumulator after this group
//             o_cont           continuation flag
//             o_nibble [3:0]   value nibble
//  Revision : 1.0  initial release
// ============================================================================
module bits_lit_group_step
    import bits_pkg::*;
(
    input  wire logic [LIT_GROUP_W-1:0] i_group,
    input  wire logic [LIT_VALUE_W-1:0] i_acc,
    output logic      [LIT_VALUE_W-1:0] o_acc,
    output logic                        o_cont,
    output logic      [LIT_GROUP_W-2:0] o_nibble
);

    // The top nibble of the accumulator is shifted out; at most 16 groups
    // are ever consumed so nothing meaningful is lost.
    logic w_unused_acc_top;

    assign o_cont           = i_group[LIT_GROUP_W-1];
    assign o_nibble         = i_group[LIT_GROUP_W-2:0];
    assign o_acc            = {i_acc[LIT_VALUE_W-LIT_GROUP_W:0], o_nibble};
    assign w_unused_acc_top = ^i_acc[LIT_VALUE_W-1:LIT_VALUE_W-LIT_GROUP_W+1];

endmodule : bits_lit_group_step
`default_nettype wire

// File: rtl/bits_literal_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : bits_literal_decoder
//  Purpose  : Multi-cycle decoder for BITS literal-value payloads. Walks
//             5-bit groups of an 80-bit MSB-aligned window, one group per
//             cycle (two when BITS_LITDEC_DUAL_EN is defined), and returns
//             the 64-bit value, bits consumed and a completion strobe.
//  Ports    : clk     system clock, rising edge
//             resetB  asynchronous active-low reset
//             lit     bits_literal_decoder_if.slave handshake
//  Config   : BITS_LITDEC_DUAL_EN  consume two groups per DECODE cycle
//  Revision : 1.0  initial release
// ============================================================================
module bits_literal_decoder
    import bits_pkg::*;
(
    input  wire logic             clk,
    input  wire logic             resetB,
    bits_literal_decoder_if.slave lit
);

    localparam logic [LIT_CNT_W-1:0] c_max_cnt = LIT_CNT_W'(LIT_MAX_GROUPS);

    lit_state_t              r_state;
    logic [LIT_WINDOW_W-1:0] r_sreg;
    logic [LIT_VALUE_W-1:0]  r_acc;
    logic [LIT_CNT_W-1:0]    r_cnt;
    logic [LIT_VALUE_W-1:0]  r_value;
    logic [LIT_BITS_W-1:0]   r_bits;
    logic                    r_valid;
    logic                    r_busy;
    logic                    r_overflow;

    logic [LIT_VALUE_W-1:0]  w_acc0;
    logic                    w_cont0;
    logic [LIT_GROUP_W-2:0]  w_nib0;

    logic [LIT_VALUE_W-1:0]  w_acc_next;
    logic [LIT_WINDOW_W-1:0] w_sreg_next;
    logic [LIT_CNT_W-1:0]    w_cnt_next;
    logic                    w_more;      // continuation of last group taken
    logic                    w_limit;
    logic                    w_exit;
    logic [LIT_BITS_W-1:0]   w_bits;
    logic                    w_unused_nib;

    bits_lit_group_step u_step0 (
        .i_group  (r_sreg[LIT_WINDOW_W-1 -: LIT_GROUP_W]),
        .i_acc    (r_acc),
        .o_acc    (w_acc0),
        .o_cont   (w_cont0),
        .o_nibble (w_nib0)
    );

`ifdef BITS_LITDEC_DUAL_EN
    logic [LIT_VALUE_W-1:0]  w_acc1;
    logic                    w_cont1;
    logic [LIT_GROUP_W-2:0]  w_nib1;

    // Second group is chained onto the first step's accumulator and is only
    // committed when the first group says more groups follow.
    bits_lit_group_step u_step1 (
        .i_group  (r_sreg[LIT_WINDOW_W-LIT_GROUP_W-1 -: LIT_GROUP_W]),
        .i_acc    (w_acc0),
        .o_acc    (w_acc1),
        .o_cont   (w_cont1),
        .o_nibble (w_nib1)
    );

    always_comb begin
        w_acc_next  = w_acc0;
        w_sreg_next = {r_sreg[LIT_WINDOW_W-LIT_GROUP_W-1:0], {LIT_GROUP_W{1'b0}}};
        w_cnt_next  = r_cnt + LIT_CNT_W'(1);
        w_more      = w_cont0;
        if (w_cont0) begin
            w_acc_next  = w_acc1;
            w_sreg_next = {r_sreg[LIT_WINDOW_W-2*LIT_GROUP_W-1:0], {(2*LIT_GROUP_W){1'b0}}};
            w_cnt_next  = r_cnt + LIT_CNT_W'(2);
            w_more      = w_cont1;
        end
    end

    assign w_unused_nib = ^{w_nib0, w_nib1};
`else
    always_comb begin
        w_acc_next  = w_acc0;
        w_sreg_next = {r_sreg[LIT_WINDOW_W-LIT_GROUP_W-1:0], {LIT_GROUP_W{1'b0}}};
        w_cnt_next  = r_cnt + LIT_CNT_W'(1);
        w_more      = w_cont0;
    end

    assign w_unused_nib = ^w_nib0;
`endif

    // Counter only ever advances in steps that land exactly on 16, so an
    // equality test is sufficient.
    assign w_limit = (w_cnt_next == c_max_cnt);
    assign w_exit  = !w_more || w_limit;
    // x5 as (x<<2)+x, truncated to the 7-bit result width (max 80).
    assign w_bits  = (LIT_BITS_W'(w_cnt_next) << 2) + LIT_BITS_W'(w_cnt_next);

    always_ff @(posedge clk or negedge resetB) begin
        if (!resetB) begin
            r_state    <= ST_IDLE;
            r_sreg     <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_value    <= '0;
            r_bits     <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (lit.decodeNumber) begin
                        r_sreg     <= lit.encoded_number;
                        r_acc      <= '0;
                        r_cnt      <= '0;
                        r_overflow <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_DECODE;
                    end else begin
                        r_busy     <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                ST_DECODE: begin
                    // Starts arriving here are dropped, not queued.
                    r_acc  <= w_acc_next;
                    r_cnt  <= w_cnt_next;
                    r_sreg <= w_sreg_next;
                    if (w_exit) begin
                        r_value    <= w_acc_next;
                        r_bits     <= w_bits;
                        r_overflow <= w_more && w_limit;
                        r_valid    <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= ST_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign lit.decodedNumber = r_value;
    assign lit.bitsToShift   = r_bits;
    assign lit.number_valid  = r_valid;
    assign lit.busy          = r_busy;
    assign lit.overflow      = r_overflow;

endmodule : bits_literal_decoder
`default_nettype wire

// File: tb/tb_bits_literal_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bits_literal_decoder
//  Purpose  : Self-checking bench for bits_literal_decoder: table of
//             directed literal windows plus hand-written sequences for
//             ignored starts, mid-decode reset and back-to-back starts.
//  Config   : honours BITS_LITDEC_DUAL_EN for expected latency
//  Revision : 1.0  initial release
// ============================================================================
module tb_bits_literal_decoder;

    logic clk;
    logic resetB;

    int n_checks;
    int n_errors;

    bits_literal_decoder_if bus ();

    bits_literal_decoder dut (
        .clk    (clk),
        .resetB (resetB),
        .lit    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [79:0] win;
        logic [63:0] val;
        logic [6:0]  bits;
        logic        ovf;
        int          k;
    } vec_t;

    vec_t vecs[7];

    function automatic int exp_lat(input int k);
`ifdef BITS_LITDEC_DUAL_EN
        return (k + 1) / 2 + 1;
`else
        return k + 1;
`endif
    endfunction

    task automatic check(input string name, input logic [79:0] got, input logic [79:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Presents a start for one cycle, then counts cycles until number_valid.
    // lat = 1 is the first cycle after the start cycle; -1 means timeout.
    task automatic run_start(input logic [79:0] win, output int lat, output int busy_cyc);
        @(negedge clk);
        bus.encoded_number = win;
        bus.decodeNumber   = 1'b1;
        @(negedge clk);
        bus.decodeNumber   = 1'b0;
        lat      = 1;
        busy_cyc = 0;
        while (!bus.number_valid && lat < 40) begin
            if (bus.busy) busy_cyc++;
            @(negedge clk);
            lat++;
        end
        if (!bus.number_valid) lat = -1;
    endtask

    task automatic wait_valid(input int start_lat, output int lat);
        lat = start_lat;
        while (!bus.number_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.number_valid) lat = -1;
    endtask

    initial begin
        int lat;
        int bcyc;
        int seen;

        n_checks = 0;
        n_errors = 0;

        vecs[0] = '{"d2fe28", {15'b101111111000101, 65'b0}, 64'h7E5, 7'd15, 1'b0, 3};
        vecs[1] = '{"one_grp", {5'b01010, 75'b0}, 64'hA, 7'd5, 1'b0, 1};
        vecs[2] = '{"ovf16", {80{1'b1}}, 64'hFFFF_FFFF_FFFF_FFFF, 7'd80, 1'b1, 16};
        vecs[3] = '{"full16", 80'hFFFF_FFFF_FFFF_FFFF_FFEF, 64'hFFFF_FFFF_FFFF_FFFF, 7'd80, 1'b0, 16};
        vecs[4] = '{"zero", 80'h0, 64'h0, 7'd5, 1'b0, 1};
        vecs[5] = '{"four_grp", {20'b10001100101001100100, 60'b0}, 64'h1234, 7'd20, 1'b0, 4};
        vecs[6] = '{"trail_ones", {10'b1101000101, {70{1'b1}}}, 64'hA5, 7'd10, 1'b0, 2};

        resetB             = 1'b0;
        bus.decodeNumber   = 1'b0;
        bus.encoded_number = '0;
        repeat (3) @(negedge clk);

        check("rst_value", 80'(bus.decodedNumber), 80'h0);
        check("rst_bits",  80'(bus.bitsToShift),   80'h0);
        check("rst_valid", 80'(bus.number_valid),  80'h0);
        check("rst_busy",  80'(bus.busy),          80'h0);
        check("rst_ovf",   80'(bus.overflow),      80'h0);

        resetB = 1'b1;
        repeat (2) @(negedge clk);

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 7; i++) begin
            run_start(vecs[i].win, lat, bcyc);
            check({vecs[i].name, "_lat"},   80'(lat),               80'(exp_lat(vecs[i].k)));
            check({vecs[i].name, "_value"}, 80'(bus.decodedNumber), 80'(vecs[i].val));
            check({vecs[i].name, "_bits"},  80'(bus.bitsToShift),   80'(vecs[i].bits));
            check({vecs[i].name, "_ovf"},   80'(bus.overflow),      80'(vecs[i].ovf));
            check({vecs[i].name, "_busy"},  80'(bcyc),              80'(exp_lat(vecs[i].k) - 1));
            @(negedge clk);
            check({vecs[i].name, "_pulse"}, 80'(bus.number_valid),  80'h0);
            check({vecs[i].name, "_hold"},  80'(bus.decodedNumber), 80'(vecs[i].val));
        end

        // ---------------- start during DECODE is ignored ----------------
        @(negedge clk);
        bus.encoded_number = {15'b101111111000101, 65'b0};
        bus.decodeNumber   = 1'b1;
        @(negedge clk);                       // start + 1
        bus.decodeNumber   = 1'b0;
        @(negedge clk);                       // start + 2: DECODE in both builds
        bus.encoded_number = {5'b01010, 75'b0};
        bus.decodeNumber   = 1'b1;
        check("ign_busy", 80'(bus.busy), 80'h1);
        @(negedge clk);                       // start + 3
        bus.decodeNumber   = 1'b0;
        wait_valid(3, lat);
        check("ign_lat",   80'(lat),               80'(exp_lat(3)));
        check("ign_value", 80'(bus.decodedNumber), 80'h7E5);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.number_valid || bus.busy) seen++;
        end
        check("ign_noreq", 80'(seen), 80'h0);

        // ---------------- reset mid-DECODE ----------------
        @(negedge clk);
        bus.encoded_number = {25'b1000110001100011000100001, 55'b0};
        bus.decodeNumber   = 1'b1;
        @(negedge clk);
        bus.decodeNumber   = 1'b0;
        @(negedge clk);                       // start + 2
        resetB = 1'b0;
        #1;
        check("mrst_value", 80'(bus.decodedNumber), 80'h0);
        check("mrst_bits",  80'(bus.bitsToShift),   80'h0);
        check("mrst_busy",  80'(bus.busy),          80'h0);
        check("mrst_valid", 80'(bus.number_valid),  80'h0);
        @(negedge clk);
        resetB = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.number_valid) seen++;
        end
        check("mrst_novalid", 80'(seen), 80'h0);

        // ---------------- back-to-back start in DONE ----------------
        run_start({15'b101111111000101, 65'b0}, lat, bcyc);
        check("b2b_lat1",   80'(lat),               80'(exp_lat(3)));
        check("b2b_value1", 80'(bus.decodedNumber), 80'h7E5);
        bus.encoded_number = {5'b00111, 75'b0};
        bus.decodeNumber   = 1'b1;            // presented in the DONE cycle
        @(negedge clk);
        bus.decodeNumber   = 1'b0;
        check("b2b_busy",   80'(bus.busy),          80'h1);
        check("b2b_gap",    80'(bus.number_valid),  80'h0);
        @(negedge clk);
        check("b2b_valid2", 80'(bus.number_valid),  80'h1);
        check("b2b_value2", 80'(bus.decodedNumber), 80'h7);
        check("b2b_bits2",  80'(bus.bitsToShift),   80'd5);
        check("b2b_ovf2",   80'(bus.overflow),      80'h0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_bits_literal_decoder
`default_nettype wire
